// File: rtl/cpu_pkg.sv
// Shared types for the CPU memory path: access FSM states,
// operation encoding and default bus widths.
package cpu_pkg;

    localparam int ADDR_W_DFLT = 9;
    localparam int DATA_W_DFLT = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        DONE
    } mem_state_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } mem_op_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Memory-side bus between the access controller and the
// 512x32 memory subsystem.
interface mem_access_ctrl_if
    import cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DFLT,
    parameter int DATA_W = DATA_W_DFLT
);

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_datain;
    logic              mem_write;
    logic [DATA_W-1:0] mem_dataout;

    modport master (
        output mem_addr,
        output mem_datain,
        output mem_write,
        input  mem_dataout
    );

    modport slave (
        input  mem_addr,
        input  mem_datain,
        input  mem_write,
        output mem_dataout
    );

endinterface

// File: rtl/mar_mdr_regs.sv
// MAR and MDR holding registers; the MDR takes either the
// datapath bus or captured memory read data.
module mar_mdr_regs
    import cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DFLT,
    parameter int DATA_W = DATA_W_DFLT
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              mar_ld,
    input  logic              mdr_ld,
    input  logic              mdr_cap,
    input  logic [DATA_W-1:0] mem_dataout,
    output logic [ADDR_W-1:0] mar,
    output logic [DATA_W-1:0] mdr
);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            mar <= '0;
            mdr <= '0;
        end else begin
            if (mar_ld)
                mar <= bus_in[ADDR_W-1:0];
            if (mdr_cap)
                mdr <= mem_dataout;
            else if (mdr_ld)
                mdr <= bus_in;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-word memory access sequencer: fixed wait states, one
// access cycle, one done cycle; requests while busy are dropped.
module mem_access_ctrl
    import cpu_pkg::*;
#(
    parameter int          ADDR_W      = ADDR_W_DFLT,
    parameter int          DATA_W      = DATA_W_DFLT,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              mar_in,
    input  logic              mdr_in,
    input  logic              rd_req,
    input  logic              wr_req,
    output logic              busy,
    output logic              done,
    output logic              req_err,
    output logic [DATA_W-1:0] mdr_out,
    mem_access_ctrl_if.master mem
);

    localparam logic [3:0] CNT_INIT =
        (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    mem_state_t        state, state_nx;
    mem_op_t           op, op_nx;
    logic [3:0]        cnt, cnt_nx;
    logic              err_q, err_nx;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] mdr;
    logic              idle;
    logic              in_access;

    assign idle      = (state == IDLE);
    assign in_access = (state == ACCESS);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= IDLE;
            op    <= OP_RD;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            op    <= op_nx;
            cnt   <= cnt_nx;
            err_q <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        op_nx    = op;
        cnt_nx   = cnt;
        err_nx   = 1'b0;
        unique case (state)
            IDLE: begin
                if (rd_req && wr_req) begin
                    err_nx = 1'b1;
                end else if (rd_req || wr_req) begin
                    op_nx    = wr_req ? OP_WR : OP_RD;
                    cnt_nx   = CNT_INIT;
                    state_nx = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0)
                    state_nx = ACCESS;
                else
                    cnt_nx = cnt - 4'd1;
            end
            ACCESS: state_nx = DONE;
            DONE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // Requests arriving mid-transaction are never queued
        if (!idle && (rd_req || wr_req))
            err_nx = 1'b1;
    end

    mar_mdr_regs #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_regs (
        .clk         (clk),
        .clr_n       (clr_n),
        .bus_in      (bus_in),
        .mar_ld      (idle && mar_in),
        .mdr_ld      (idle && mdr_in),
        .mdr_cap     (in_access && (op == OP_RD)),
        .mem_dataout (mem.mem_dataout),
        .mar         (mar),
        .mdr         (mdr)
    );

    assign busy           = !idle;
    assign done           = (state == DONE);
    assign req_err        = err_q;
    assign mdr_out        = mdr;
    assign mem.mem_addr   = mar;
    assign mem.mem_datain = mdr;
    assign mem.mem_write  = in_access && (op == OP_WR);

endmodule
